seq_step_ctrl: RTL

//  Controller that sequences the 8-entry up/down sequence stepper.

---
 rtl/seq_pkg.sv | 35 +++
 rtl/step_tick_gen.sv | 44 ++++
 rtl/seq_step_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-stepper controller.
// mode_t  : command mode encoding as presented on cmd_mode.
// state_t : controller FSM states.
// SEQ_LEN : sequence length; positions run 0..SEQ_LEN-1.
// POS_W   : width of the position register and pos output.
package seq_pkg;

    typedef enum logic [1:0] {
        ONESHOT = 2'd0,
        CONT    = 2'd1,
        BOUNCE  = 2'd2,
        RSVD    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEQ_LEN = 8;
    localparam int POS_W   = 3;

    // Reserved encoding behaves as ONESHOT.
    function automatic mode_t norm_mode(input logic [1:0] m);
        mode_t r;
        case (m)
            2'd1:    r = CONT;
            2'd2:    r = BOUNCE;
            default: r = ONESHOT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Rate divider for the step controller.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-low reset
//   clr_i   in   force the divider count back to zero
//   en_i    in   advance the divider this cycle
//   div_i   in   cycles per tick (must be >= 1)
//   tick_o  out  high while the count sits at div_i-1 (the cycle that steps)
module step_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] divcnt_q;
    logic [DIV_W-1:0] divcnt_d;
    logic [DIV_W-1:0] div_m1;

    assign div_m1 = div_i - 1'b1;
    assign tick_o = (divcnt_q == div_m1);

    always_comb begin
        divcnt_d = divcnt_q;
        if (clr_i) begin
            divcnt_d = '0;
        end else if (en_i) begin
            divcnt_d = tick_o ? '0 : divcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            divcnt_q <= '0;
        end else begin
            divcnt_q <= divcnt_d;
        end
    end

endmodule

// File: rtl/seq_step_ctrl.sv
// Command sequencer for the 8-entry up/down stepper.
// Accepts (mode, dir, count, div) over a valid/ready handshake, emits
// rate-divided one-cycle step pulses with direction, and mirrors the
// stepper position.
// Ports:
//   clk, rst            clock / synchronous active-low reset
//   cmd_valid/cmd_ready command handshake; ready only in IDLE
//   cmd_mode            0 ONESHOT, 1 CONT, 2 BOUNCE, 3 as ONESHOT
//   cmd_dir             initial direction, 1 = up
//   cmd_count           steps for ONESHOT
//   cmd_div             clock cycles per step, 0 treated as 1
//   stop                abort a running command
//   step, dir_up, pos   registered step pulse, direction, position
//   busy, done          busy in RUN/DONE; one-cycle completion pulse
module seq_step_ctrl
    import seq_pkg::*;
#(
    parameter int LEN   = SEQ_LEN,
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             stop,
    output logic             step,
    output logic             dir_up,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             done
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(LEN - 1);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             done_q, done_d;

    logic             tick;
    logic             tick_clr;
    logic             tick_en;
    logic [POS_W-1:0] pos_inc;
    logic [POS_W-1:0] pos_dec;

    assign pos_inc = pos_q + 1'b1;
    assign pos_dec = pos_q - 1'b1;

    step_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tick_clr),
        .en_i   (tick_en),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        div_d    = div_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        tick_clr = 1'b1;
        tick_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = RUN;
                    mode_d  = norm_mode(cmd_mode);
                    div_d   = (cmd_div == '0) ? DIV_W'(1) : cmd_div;
                    rem_d   = cmd_count;
                    dir_d   = cmd_dir;
                end
            end

            RUN: begin
                if (stop || (mode_q == ONESHOT && rem_q == '0)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    tick_clr = 1'b0;
                    tick_en  = 1'b1;
                    if (tick) begin
                        step_d = 1'b1;
                        if (mode_q == ONESHOT) begin
                            rem_d = rem_q - 1'b1;
                        end
                        if (mode_q == BOUNCE) begin
                            // Reflect at the ends; direction flips on the
                            // edge that lands on an end. A command started
                            // on an end pointing outward reflects at once.
                            if (dir_q) begin
                                if (pos_q == POS_MAX) begin
                                    pos_d = pos_dec;
                                    dir_d = 1'b0;
                                end else begin
                                    pos_d = pos_inc;
                                    if (pos_inc == POS_MAX) dir_d = 1'b0;
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    pos_d = pos_inc;
                                    dir_d = 1'b1;
                                end else begin
                                    pos_d = pos_dec;
                                    if (pos_dec == '0) dir_d = 1'b1;
                                end
                            end
                        end else begin
                            if (dir_q) begin
                                pos_d = (pos_q == POS_MAX) ? '0 : pos_inc;
                            end else begin
                                pos_d = (pos_q == '0) ? POS_MAX : pos_dec;
                            end
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= ONESHOT;
            div_q   <= DIV_W'(1);
            rem_q   <= '0;
            dir_q   <= 1'b1;
            pos_q   <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign step      = step_q;
    assign done      = done_q;
    assign dir_up    = dir_q;
    assign pos       = pos_q;

endmodule
